// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the request legality check used when a request is accepted.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } lsu_state_e;

    // limit is the first illegal byte address (4 * number of words).
    function automatic logic lsu_req_err(input logic        we,
                                         input logic [2:0]  funct3,
                                         input logic [31:0] addr,
                                         input logic [32:0] limit);
        logic bad;
        bad = 1'b0;
        case (funct3)
            F3_B:    bad = 1'b0;
            F3_BU:   bad = we;
            F3_H:    bad = addr[0];
            F3_HU:   bad = we | addr[0];
            F3_W:    bad = (addr[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        if ({1'b0, addr} >= limit) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte/halfword lane handling: extracts and extends load data from a memory
// word, and merges store data into a word for read-modify-write.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [31:0] shifted;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        shifted = word >> {offset, 3'b000};
        lane_b  = shifted[7:0];
        lane_h  = offset[1] ? word[31:16] : word[15:0];

        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
            F3_BU:   load_data = {24'h0, lane_b};
            F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
            F3_HU:   load_data = {16'h0, lane_h};
            F3_W:    load_data = word;
            default: load_data = '0;
        endcase

        store_word = word;
        case (funct3)
            F3_B: begin
                case (offset)
                    2'd0:    store_word[7:0]   = wdata[7:0];
                    2'd1:    store_word[15:8]  = wdata[7:0];
                    2'd2:    store_word[23:16] = wdata[7:0];
                    default: store_word[31:24] = wdata[7:0];
                endcase
            end
            F3_H: begin
                if (offset[1]) store_word[31:16] = wdata[15:0];
                else           store_word[15:0]  = wdata[15:0];
            end
            F3_W:    store_word = wdata;
            default: store_word = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-wide asynchronous-read data memory;
// sub-word stores are done as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [2:0]  dbg_state
);

    localparam logic [32:0] ADDR_LIMIT = 33'(4 * MEM_WORDS);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both 1; valid never waits for ready, and the response holds its
    // data stable while rsp_valid=1 and rsp_ready=0.

    lsu_state_e  state_q, state_d;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic [31:0] mem_wdata_q;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] store_word;

    assign req_err = lsu_req_err(req_we, req_funct3, req_addr, ADDR_LIMIT);

    lsu_align u_align (
        .funct3     (funct3_q),
        .offset     (addr_q[1:0]),
        .word       (mem_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)                 state_d = RESP;
                    else if (!req_we)            state_d = LOAD;
                    else if (req_funct3 == F3_W) state_d = WRITE;
                    else                         state_d = MERGE;
                end
            end
            LOAD:    state_d = RESP;
            MERGE:   state_d = WRITE;
            WRITE:   state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            funct3_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q        <= req_we;
                        funct3_q    <= req_funct3;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        rsp_err_q   <= req_err;
                        rsp_rdata_q <= '0;
                        if (req_we && req_funct3 == F3_W && !req_err) begin
                            mem_wdata_q <= req_wdata;
                        end
                    end
                end
                LOAD:  rsp_rdata_q <= load_data;
                MERGE: mem_wdata_q <= store_word;
                RESP: begin
                    if (rsp_ready) begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // rst gates the strobe combinationally so an aborted WRITE never lands.
    assign mem_we    = (state_q == WRITE) && we_q && !rst;
    assign mem_addr  = (state_q == IDLE) ? 32'h0 : {addr_q[31:2], 2'b00};
    assign mem_wdata = mem_wdata_q;
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, multi-cycle corner cases
// and randomized traffic scored against a byte-level memory model.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int MEM_WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [2:0]  dbg_state;

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    logic [32:0] exp_q[$];

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / memory ----------------
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[11:2]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference behaviour from the architectural rules: byte arithmetic on a word array.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wd, output logic err, output logic [31:0] rd,
                                  output int lat, output int we_at);
        int nbytes;
        int off;
        longint a;
        logic [31:0] w, v, mask;
        a = addr;
        err = 1'b0; rd = '0; lat = 2; we_at = -1;
        case (f3)
            3'd0, 3'd4: nbytes = 1;
            3'd1, 3'd5: nbytes = 2;
            3'd2:       nbytes = 4;
            default: begin nbytes = 1; err = 1'b1; end
        endcase
        if (we && (f3 == 3'd4 || f3 == 3'd5)) err = 1'b1;
        if (a % nbytes != 0) err = 1'b1;
        if (a >= 4 * MEM_WORDS) err = 1'b1;
        if (err) begin
            lat = 1;
            return;
        end
        w   = ref_mem[a / 4];
        off = int'(a % 4);
        if (!we) begin
            v = w >> (8 * off);
            if (nbytes == 1) v = v & 32'hFF;
            if (nbytes == 2) v = v & 32'hFFFF;
            if (f3 == 3'd0 && v >= 128)   v = v - 256;
            if (f3 == 3'd1 && v >= 32768) v = v - 65536;
            rd = v;
        end else if (nbytes == 4) begin
            ref_mem[a / 4] = wd;
            we_at = 1;
        end else begin
            mask = ((nbytes == 1) ? 32'hFF : 32'hFFFF) << (8 * off);
            ref_mem[a / 4] = (w & ~mask) | ((wd << (8 * off)) & mask);
            lat = 3;
            we_at = 2;
        end
    endfunction

    // ---------------- driver ----------------
    // Cycle k counts negedges after the accept edge N; a signal seen there is sampled at edge N+k.
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int hold,
                       output logic [31:0] rd, output logic err, output int lat,
                       output int we_at, output int we_cnt);
        bit done;
        @(negedge clk);
        check("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        rd = '0; err = 1'b0; lat = -1; we_at = -1; we_cnt = 0; done = 1'b0;
        for (int k = 1; k <= 20 && !done; k++) begin
            @(negedge clk);
            if (k == 1) check("mem_addr", mem_addr, {addr[31:2], 2'b00});
            if (mem_we) begin
                we_cnt++;
                we_at = k;
            end
            if (rsp_valid) begin
                lat = k; rd = rsp_rdata; err = rsp_err;
                for (int h = 0; h < hold; h++) begin
                    @(negedge clk);
                    if (mem_we) we_cnt++;
                    check("hold_valid", {31'b0, rsp_valid}, 32'd1);
                    check("hold_rdata", rsp_rdata, rd);
                    check("hold_err", {31'b0, rsp_err}, {31'b0, err});
                    check("hold_req_ready", {31'b0, req_ready}, 32'd0);
                end
                rsp_ready = 1'b1;
                @(posedge clk);
                #1;
                rsp_ready = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) begin
            n_vec++;
            n_miss++;
            $display("FAIL rsp_timeout: got no rsp_valid expected one within 20 cycles");
        end
    endtask

    task automatic scored_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input int hold);
        logic        e_err, a_err;
        logic [31:0] e_rd, a_rd;
        logic [32:0] e;
        int e_lat, e_we, a_lat, a_we, a_cnt;
        model(we, f3, addr, wd, e_err, e_rd, e_lat, e_we);
        exp_q.push_back({e_err, e_rd});
        txn(we, f3, addr, wd, hold, a_rd, a_err, a_lat, a_we, a_cnt);
        e = exp_q.pop_front();
        check("rnd_rdata", a_rd, e[31:0]);
        check("rnd_err", {31'b0, a_err}, {31'b0, e[32]});
        check("rnd_latency", a_lat, e_lat);
        check("rnd_we_cycle", a_we, e_we);
        check("rnd_we_count", a_cnt, (e_we > 0) ? 32'd1 : 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_we_at;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic        a_err, m_err;
        logic [31:0] a_rd, m_rd;
        int a_lat, a_we, a_cnt, m_lat, m_we;

        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = '0;

        // ---------------- reset ----------------
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_mem_we", {31'b0, mem_we}, 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_mem_wdata", mem_wdata, 32'd0);
        check("reset_state", {29'b0, dbg_state}, 32'(IDLE));
        rst = 1'b0;

        // ---------------- directed table ----------------
        vecs.push_back('{1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 2, 1});
        vecs.push_back('{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 2, -1});
        vecs.push_back('{1'b1, 3'b010, 32'h10,  32'h11223344, 32'h0,        1'b0, 2, 1});
        vecs.push_back('{1'b1, 3'b000, 32'h12,  32'h000000AA, 32'h0,        1'b0, 3, 2});
        vecs.push_back('{1'b0, 3'b010, 32'h10,  32'h0,        32'h11AA3344, 1'b0, 2, -1});
        vecs.push_back('{1'b0, 3'b000, 32'h12,  32'h0,        32'hFFFFFFAA, 1'b0, 2, -1});
        vecs.push_back('{1'b0, 3'b100, 32'h12,  32'h0,        32'h000000AA, 1'b0, 2, -1});
        vecs.push_back('{1'b0, 3'b001, 32'h12,  32'h0,        32'h000011AA, 1'b0, 2, -1});
        vecs.push_back('{1'b0, 3'b101, 32'h10,  32'h0,        32'h00003344, 1'b0, 2, -1});
        vecs.push_back('{1'b1, 3'b010, 32'h20,  32'hCAFEF00D, 32'h0,        1'b0, 2, 1});
        vecs.push_back('{1'b1, 3'b001, 32'h21,  32'h00001234, 32'h0,        1'b1, 1, -1});
        vecs.push_back('{1'b0, 3'b010, 32'h22,  32'h0,        32'h0,        1'b1, 1, -1});
        vecs.push_back('{1'b0, 3'b010, 32'h20,  32'h0,        32'hCAFEF00D, 1'b0, 2, -1});
        vecs.push_back('{1'b0, 3'b010, 32'h1000, 32'h0,       32'h0,        1'b1, 1, -1});
        vecs.push_back('{1'b1, 3'b001, 32'hFFE, 32'h12348001, 32'h0,        1'b0, 3, 2});
        vecs.push_back('{1'b0, 3'b001, 32'hFFE, 32'h0,        32'hFFFF8001, 1'b0, 2, -1});
        vecs.push_back('{1'b0, 3'b011, 32'h10,  32'h0,        32'h0,        1'b1, 1, -1});
        vecs.push_back('{1'b0, 3'b111, 32'h0,   32'h0,        32'h0,        1'b1, 1, -1});
        vecs.push_back('{1'b1, 3'b100, 32'h10,  32'h000000FF, 32'h0,        1'b1, 1, -1});
        vecs.push_back('{1'b1, 3'b001, 32'h12,  32'hFFFFBEEF, 32'h0,        1'b0, 3, 2});
        vecs.push_back('{1'b0, 3'b010, 32'h10,  32'h0,        32'hBEEF3344, 1'b0, 2, -1});
        vecs.push_back('{1'b1, 3'b000, 32'h13,  32'h0000007F, 32'h0,        1'b0, 3, 2});
        vecs.push_back('{1'b0, 3'b000, 32'h13,  32'h0,        32'h0000007F, 1'b0, 2, -1});
        vecs.push_back('{1'b0, 3'b001, 32'h12,  32'h0,        32'h00007FEF, 1'b0, 2, -1});

        for (int i = 0; i < vecs.size(); i++) begin
            model(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd, m_err, m_rd, m_lat, m_we);
            txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd, 0, a_rd, a_err, a_lat, a_we, a_cnt);
            check($sformatf("vec%0d_rdata", i), a_rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_err", i), {31'b0, a_err}, {31'b0, vecs[i].exp_err});
            check($sformatf("vec%0d_latency", i), a_lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_we_cycle", i), a_we, vecs[i].exp_we_at);
            check($sformatf("vec%0d_we_count", i), a_cnt, (vecs[i].exp_we_at > 0) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        check("mem_word_0x10", mem[4], 32'h7FEF3344);
        check("mem_word_0x20_untouched", mem[8], 32'hCAFEF00D);

        // ---------------- response back-pressure ----------------
        txn(1'b0, F3_W, 32'h10, 32'h0, 5, a_rd, a_err, a_lat, a_we, a_cnt);
        check("bp_rdata", a_rd, 32'h7FEF3344);
        check("bp_err", {31'b0, a_err}, 32'd0);
        check("bp_latency", a_lat, 32'd2);

        // ---------------- reset during MERGE of SB 0x30 ----------------
        txn(1'b1, F3_W, 32'h30, 32'h55667788, 0, a_rd, a_err, a_lat, a_we, a_cnt);
        txn(1'b1, F3_W, 32'h34, 32'h01020304, 0, a_rd, a_err, a_lat, a_we, a_cnt);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B; req_addr = 32'h30; req_wdata = 32'hAA;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("abort_merge_entered", {29'b0, dbg_state}, 32'(MERGE));
        rst = 1'b1;
        @(negedge clk);
        check("abort_merge_no_we", {31'b0, mem_we}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_merge_state", {29'b0, dbg_state}, 32'(IDLE));
        check("abort_merge_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("abort_merge_we_after", {31'b0, mem_we}, 32'd0);
        end
        check("abort_merge_mem", mem[12], 32'h55667788);

        // ---------------- reset during WRITE of SW 0x34 ----------------
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h34; req_wdata = 32'h99999999;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("abort_write_no_we", {31'b0, mem_we}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_write_state", {29'b0, dbg_state}, 32'(IDLE));
        @(negedge clk);
        check("abort_write_mem", mem[13], 32'h01020304);

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 16; i++) begin
            scored_txn(1'b1, F3_W, 32'(i * 4), $urandom, 0);
        end
        for (int i = 0; i < 300; i++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] addr;
            int          sel;
            we = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 19);
            case (sel)
                0:       f3 = 3'b011;
                1:       f3 = 3'b110;
                2:       f3 = 3'b111;
                default: begin
                    case ($urandom_range(0, 4))
                        0:       f3 = F3_B;
                        1:       f3 = F3_H;
                        2:       f3 = F3_W;
                        3:       f3 = F3_BU;
                        default: f3 = F3_HU;
                    endcase
                end
            endcase
            if ($urandom_range(0, 19) == 0) addr = $urandom_range(4096, 4200);
            else                            addr = $urandom_range(0, 63);
            scored_txn(we, f3, addr, $urandom, $urandom_range(0, 2));
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024: number of 32-bit words in the data memory; the legal byte range is 0 to 4*MEM_WORDS-1.
REQ-002 SHALL have clk, input, 1: clock; all state updates on its rising edge.
REQ-003 SHALL have rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have req_valid, input, 1: CPU request present.
REQ-005 SHALL have req_ready, output, 1: unit can accept a request.
REQ-006 SHALL have req_we, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have req_funct3, input, 3: RV32I width code; 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have req_addr, input, 32: byte address.
REQ-009 SHALL have req_wdata, input, 32: store data, right-aligned.
REQ-010 SHALL have rsp_valid, output, 1: response present.
REQ-011 SHALL have rsp_ready, input, 1: CPU accepts the response.
REQ-012 SHALL have rsp_rdata, output, 32: load result, extended; 0 for stores and errors.
REQ-013 SHALL have rsp_err, output, 1: the request was misaligned, out of range, or had an illegal funct3.
REQ-014 SHALL have mem_we, output, 1: word write strobe to the data memory.
REQ-015 SHALL have mem_addr, output, 32: byte address to the data memory; bits [1:0] always 0.
REQ-016 SHALL have mem_wdata, output, 32: full word to write.
REQ-017 SHALL have mem_rdata, input, 32: asynchronous word read data from mem_addr.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, MERGE, WRITE, RESP; req_ready=1 only in IDLE.
REQ-019 SHALL in IDLE, on req_valid, latch req_we, req_funct3, req_addr and req_wdata.
REQ-020 SHALL in IDLE, on req_valid with an error condition, go to RESP with rsp_err=1 and never assert mem_we.
REQ-021 SHALL in IDLE, on a legal request, go to LOAD for a load, WRITE for a store word, or MERGE for a store byte or halfword.
REQ-022 SHALL treat as errors: H/HU with addr[0]=1; W with addr[1:0]!=00; addr>=4*MEM_WORDS; funct3 in {011,110,111}; store with funct3 100 or 101.
REQ-023 SHALL in LOAD drive mem_addr={addr[31:2],2'b00}, register the extracted lane (sign-extend B/H, zero-extend BU/HU) into rsp_rdata, then go to RESP.
REQ-024 SHALL in MERGE register mem_rdata with the selected byte or halfword lane replaced from req_wdata[7:0] or [15:0], then go to WRITE.
REQ-025 SHALL in WRITE assert mem_we for exactly one cycle with mem_wdata = merged word (or req_wdata for W), then go to RESP.
REQ-026 SHALL in RESP hold rsp_valid=1 and stable rsp_rdata/rsp_err until rsp_ready=1, then return to IDLE; the next request is accepted no earlier than the following cycle.
REQ-027 SHALL meet latency from the accept edge N: load rsp_valid at N+2, SW at N+2 (mem_we at N+1), SB/SH at N+3 (mem_we at N+2).
REQ-028 SHALL keep mem_we=0 in every state except WRITE and drive mem_addr from the latched address outside IDLE.

Reset
REQ-029 SHALL on rst go to IDLE with rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_we=0, mem_wdata=0, mem_addr=0.
REQ-030 SHALL on rst asserted mid-operation (LOAD, MERGE, WRITE or RESP) abort with no mem_we in the rst cycle or after it, and drop any pending response.

Structure
REQ-031 SHALL place the funct3 width constants and the FSM state enum in shared package lsu_pkg.
REQ-032 SHALL put lane extraction/extension and store merge in one combinational sub-module lsu_align.

Verification
REQ-033 SHALL test SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> mem_we pulse at N+1, rsp_rdata=0xDEADBEEF at N+2, rsp_err=0.
REQ-034 SHALL test word 0x10=0x11223344, SB addr 0x12 data 0xAA -> written word 0x11AA3344; then LB 0x12 -> 0xFFFFFFAA and LBU 0x12 -> 0x000000AA.
REQ-035 SHALL test SH addr 0x21 and LW addr 0x22 -> rsp_err=1 at N+1, mem_we never asserted, memory unchanged.
REQ-036 SHALL test LW addr 0x1000 with MEM_WORDS=1024 -> rsp_err=1, rsp_rdata=0.
REQ-037 SHALL test rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 until the handshake completes.
REQ-038 SHALL test rst asserted in MERGE of SB 0x30 -> no mem_we, state IDLE, word 0x30 unchanged.
